// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image over 8N1 UART and writes it into program memory,
// holding the core stalled until the image checksum verifies.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          MAX_WORDS    = 256,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rx,
  output logic        o_pm_we,
  output logic [31:0] o_pm_addr,
  output logic [31:0] o_pm_wdata,
  output logic        o_cpu_run,
  output logic        o_busy,
  output logic        o_load_err,
  output logic [15:0] o_word_cnt
);
  localparam int              CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   LP_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     LP_MAX  = 16'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_RUN, S_ERR} state_t;

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  rx_state_t     r_rx_state, w_rx_state_nx;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_nx;
  logic [2:0]    r_bit_idx, w_bit_idx_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          w_fall, w_stop_pt, w_byte_vld, w_frm_err;

  state_t        r_state, w_state_nx;
  logic [15:0]   r_len, r_word_cnt;
  logic [31:0]   r_word, r_pm_addr, r_pm_wdata;
  logic [7:0]    r_chk;
  logic [1:0]    r_byte_idx;
  logic          r_pm_we, r_cpu_run, r_load_err;
  logic          w_busy, w_hdr, w_last_byte, w_last_word, w_data_byte;
  logic [15:0]   w_len;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {r_rx_s1, r_rx_s2, r_rx_s3} <= 3'b111;
    else          {r_rx_s1, r_rx_s2, r_rx_s3} <= {i_uart_rx, r_rx_s1, r_rx_s2};

  assign w_fall     = r_rx_s3 & ~r_rx_s2;
  assign w_stop_pt  = (r_rx_state == RX_STOP) && (r_clk_cnt == LP_FULL);
  assign w_byte_vld = w_stop_pt & r_rx_s2;
  assign w_frm_err  = w_stop_pt & ~r_rx_s2;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_clk_cnt  <= w_clk_cnt_nx;
      r_bit_idx  <= w_bit_idx_nx;
      r_shift    <= w_shift_nx;
    end

  // A start bit still high at its centre is treated as a line glitch.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_clk_cnt_nx  = r_clk_cnt + 1'b1;
    w_bit_idx_nx  = r_bit_idx;
    w_shift_nx    = r_shift;
    case (r_rx_state)
      RX_IDLE: begin
        w_clk_cnt_nx = '0;
        if (w_fall) w_rx_state_nx = RX_START;
      end
      RX_START:
        if (r_clk_cnt == LP_HALF) begin
          w_clk_cnt_nx  = '0;
          w_bit_idx_nx  = '0;
          w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (r_clk_cnt == LP_FULL) begin
          w_clk_cnt_nx = '0;
          w_shift_nx   = {r_rx_s2, r_shift[7:1]};
          w_bit_idx_nx = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_rx_state_nx = RX_STOP;
        end
      RX_STOP:
        if (r_clk_cnt == LP_FULL) w_rx_state_nx = RX_IDLE;
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  assign w_busy      = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_hdr       = w_byte_vld && (r_shift == HDR_BYTE);
  assign w_len       = {r_shift, r_len[7:0]};
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_cnt + 16'd1) == r_len;
  assign w_data_byte = (r_state == S_DATA) && w_byte_vld;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERR: if (w_hdr) w_state_nx = S_LEN_LO;
      S_LEN_LO: if (w_byte_vld) w_state_nx = S_LEN_HI;
      S_LEN_HI: if (w_byte_vld) w_state_nx = (w_len > LP_MAX) ? S_ERR : (w_len == 16'd0) ? S_CHK : S_DATA;
      S_DATA:   if (w_byte_vld && w_last_byte && w_last_word) w_state_nx = S_CHK;
      S_CHK:    if (w_byte_vld) w_state_nx = (r_shift == r_chk) ? S_RUN : S_ERR;
      default:  w_state_nx = S_IDLE;
    endcase
    if (w_frm_err && w_busy) w_state_nx = S_ERR;
  end

  // Word assembly and the write port are separate registers, so a byte can land during the write cycle.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
      r_cpu_run  <= 1'b0;
      r_load_err <= 1'b0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_word     <= '0;
      r_chk      <= '0;
      r_byte_idx <= '0;
    end else begin
      r_pm_we    <= 1'b0;
      r_cpu_run  <= (r_state == S_RUN);
      r_load_err <= (w_state_nx == S_ERR);
      if (w_hdr && !w_busy) begin
        r_word_cnt <= '0;
        r_pm_addr  <= '0;
        r_chk      <= '0;
        r_byte_idx <= '0;
      end
      if ((r_state == S_LEN_LO) && w_byte_vld) r_len[7:0] <= r_shift;
      if ((r_state == S_LEN_HI) && w_byte_vld) r_len <= w_len;
      if (w_data_byte) begin
        r_chk                            <= r_chk + r_shift;
        r_word[{r_byte_idx, 3'b000} +: 8] <= r_shift;
        r_byte_idx                       <= r_byte_idx + 2'd1;
        if (w_last_byte) begin
          r_pm_we    <= 1'b1;
          r_pm_wdata <= {r_shift, r_word[23:0]};
          r_pm_addr  <= {14'd0, r_word_cnt, 2'b00};
          r_word_cnt <= r_word_cnt + 16'd1;
        end
      end
    end

  assign o_pm_we    = r_pm_we;
  assign o_pm_addr  = r_pm_addr;
  assign o_pm_wdata = r_pm_wdata;
  assign o_cpu_run  = r_cpu_run;
  assign o_busy     = w_busy;
  assign o_load_err = r_load_err;
  assign o_word_cnt = r_word_cnt;
endmodule
